mult_reservation_station: RTL and testbench

Reservation station for the multiply functional unit in the Tomasulo out-of-order core. It accepts issued multiply instructions whose operands may still be pending, and snoops the common data bus (CDB) to capture operands as they are produced. Each cycle it dispatches at most one ready entry to the multiplier over `calculate`/`a`/`b`/`row`, then frees the entry when the multiplier's result with that tag appears on the CDB.

---
 rtl/tomasulo_pkg.sv | 34 +++
 rtl/lowest_set_index.sv | 30 +++
 rtl/mult_reservation_station.sv | 160 ++++++++++++++++
 tb/tb_mult_reservation_station.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_pkg
// Description : Shared types and constants for the Tomasulo reservation
//               stations (tag width, empty-tag marker, slot entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

    // Tag width shared by the adder and multiplier stations.
    localparam int TAG_W = 4;

    // Tag value meaning "operand value is present".
    localparam logic [TAG_W-1:0] NO_TAG = 4'hF;

    // Operand width carried in a station entry; a station's DATA_W must match.
    localparam int RS_DATA_W = 32;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAITING    = 2'd1,
        DISPATCHED = 2'd2
    } rs_state_t;

    typedef struct packed {
        rs_state_t              state;
        logic [RS_DATA_W-1:0]   vj;
        logic [RS_DATA_W-1:0]   vk;
        logic [TAG_W-1:0]       qj;
        logic [TAG_W-1:0]       qk;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/lowest_set_index.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_index
// Description : Priority encoder returning the index of the lowest set bit
//               of a vector together with a found flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_index #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan upward; the first set bit wins so lower indices have priority.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : mult_reservation_station
// Description : Reservation station for the multiply unit. Holds issued
//               multiplies until both operands arrive (snooped from the CDB),
//               dispatches one ready entry per cycle, and frees the entry when
//               the multiplier's result for its tag is broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE    = 4,
    parameter int DATA_W      = RS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    // Issue port
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic [TAG_W-1:0]  issue_tag,
    // Common data bus
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    // Dispatch to multiplier
    output logic              calculate,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [TAG_W-1:0]  row
);

    localparam int               c_idx_w    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [TAG_W-1:0] c_tag_base = TAG_W'(TAG_BASE);

    rs_entry_t              r_entries [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_free_vec;
    logic [NUM_ENTRIES-1:0] w_ready_vec;
    logic [c_idx_w-1:0]     w_free_idx;
    logic [c_idx_w-1:0]     w_ready_idx;
    logic                   w_free_found;
    logic                   w_ready_found;
    logic                   w_alloc;
    rs_entry_t              w_issue_entry;

    // Per-slot status vectors, derived only from registered state.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot_status
            assign w_free_vec[gi]  = (r_entries[gi].state == FREE);
            assign w_ready_vec[gi] = (r_entries[gi].state == WAITING) &&
                                     (r_entries[gi].qj == NO_TAG) &&
                                     (r_entries[gi].qk == NO_TAG);
        end
    endgenerate

    lowest_set_index #(
        .WIDTH (NUM_ENTRIES),
        .IDX_W (c_idx_w)
    ) u_free_enc (
        .vec   (w_free_vec),
        .idx   (w_free_idx),
        .found (w_free_found)
    );

    lowest_set_index #(
        .WIDTH (NUM_ENTRIES),
        .IDX_W (c_idx_w)
    ) u_ready_enc (
        .vec   (w_ready_vec),
        .idx   (w_ready_idx),
        .found (w_ready_found)
    );

    assign issue_ready = w_free_found;
    assign issue_tag   = c_tag_base + TAG_W'(w_free_idx);
    assign w_alloc     = issue_valid && w_free_found;

    // Build the entry written on allocation, bypassing a same-cycle CDB result.
    always_comb begin
        w_issue_entry       = '{state: WAITING, vj: issue_vj, vk: issue_vk,
                                qj: issue_qj, qk: issue_qk};
        if (cdb_valid && (issue_qj != NO_TAG) && (cdb_tag == issue_qj)) begin
            w_issue_entry.vj = cdb_data;
            w_issue_entry.qj = NO_TAG;
        end
        if (cdb_valid && (issue_qk != NO_TAG) && (cdb_tag == issue_qk)) begin
            w_issue_entry.vk = cdb_data;
            w_issue_entry.qk = NO_TAG;
        end
    end

    // Slot state: allocate, snoop operands, mark dispatched, free on own tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i] <= '{state: FREE, vj: '0, vk: '0, qj: NO_TAG, qk: NO_TAG};
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                case (r_entries[i].state)
                    FREE: begin
                        if (w_alloc && (w_free_idx == c_idx_w'(i))) begin
                            r_entries[i] <= w_issue_entry;
                        end
                    end
                    WAITING: begin
                        // A selected slot already has both operands, so the
                        // snoop below cannot touch it in the same cycle.
                        if (w_ready_found && (w_ready_idx == c_idx_w'(i))) begin
                            r_entries[i].state <= DISPATCHED;
                        end
                        if (cdb_valid && (r_entries[i].qj != NO_TAG) &&
                            (r_entries[i].qj == cdb_tag)) begin
                            r_entries[i].vj <= cdb_data;
                            r_entries[i].qj <= NO_TAG;
                        end
                        if (cdb_valid && (r_entries[i].qk != NO_TAG) &&
                            (r_entries[i].qk == cdb_tag)) begin
                            r_entries[i].vk <= cdb_data;
                            r_entries[i].qk <= NO_TAG;
                        end
                    end
                    DISPATCHED: begin
                        if (cdb_valid && (cdb_tag == c_tag_base + TAG_W'(i))) begin
                            r_entries[i].state <= FREE;
                        end
                    end
                    default: begin
                        r_entries[i].state <= FREE;
                    end
                endcase
            end
        end
    end

    // Registered dispatch port; operands and row hold when nothing is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            calculate <= 1'b0;
            a         <= '0;
            b         <= '0;
            row       <= NO_TAG;
        end else begin
            calculate <= w_ready_found;
            if (w_ready_found) begin
                a   <= r_entries[w_ready_idx].vj;
                b   <= r_entries[w_ready_idx].vk;
                row <= c_tag_base + TAG_W'(w_ready_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_reservation_station
// Description : Directed self-checking bench for mult_reservation_station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_reservation_station;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_vj;
    logic [31:0] issue_vk;
    logic [3:0]  issue_qj;
    logic [3:0]  issue_qk;
    logic [3:0]  issue_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        calculate;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  row;

    int checks;
    int failures;

    mult_reservation_station #(
        .NUM_ENTRIES (4),
        .TAG_BASE    (4),
        .DATA_W      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_vj    (issue_vj),
        .issue_vk    (issue_vk),
        .issue_qj    (issue_qj),
        .issue_qk    (issue_qk),
        .issue_tag   (issue_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .calculate   (calculate),
        .a           (a),
        .b           (b),
        .row         (row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; all driving and sampling happens 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_vj    = '0;
        issue_vk    = '0;
        issue_qj    = 4'hF;
        issue_qk    = 4'hF;
        cdb_valid   = 1'b0;
        cdb_tag     = 4'hF;
        cdb_data    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (a !== 32'd0 || b !== 32'd0) begin
            failures++;
            $display("FAIL reset_ab: a=%0d b=%0d expected a=0 b=0", a, b);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (calculate !== 1'b0 || row !== 4'hF || issue_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: calculate=%b row=%h issue_ready=%b expected 0 F 1",
                         c, calculate, row, issue_ready);
            end
            tick();
        end
    endtask

    task automatic test_ready_issue();
        issue_valid = 1'b1;
        issue_vj    = 32'd6;
        issue_vk    = 32'd7;
        checks++;
        if (issue_tag !== 4'd4 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_issue_tag: tag=%0d ready=%b expected 4 1", issue_tag, issue_ready);
        end
        tick();                 // E0
        idle_inputs();
        checks++;
        if (calculate !== 1'b0) begin
            failures++;
            $display("FAIL ready_issue_early: calculate=%b expected 0", calculate);
        end
        tick();                 // E1
        checks++;
        if (calculate !== 1'b1 || a !== 32'd6 || b !== 32'd7 || row !== 4'd4) begin
            failures++;
            $display("FAIL ready_issue_dispatch: calc=%b a=%0d b=%0d row=%0d expected 1 6 7 4",
                     calculate, a, b, row);
        end
        checks++;
        if (issue_tag !== 4'd5) begin
            failures++;
            $display("FAIL ready_issue_slot_busy: issue_tag=%0d expected 5", issue_tag);
        end
        tick();
        checks++;
        if (calculate !== 1'b0 || row !== 4'd4 || a !== 32'd6) begin
            failures++;
            $display("FAIL ready_issue_one_cycle: calc=%b row=%0d a=%0d expected 0 4 6", calculate, row, a);
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        cdb_data  = 32'd42;
        tick();
        idle_inputs();
        checks++;
        if (issue_tag !== 4'd4 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_issue_free: issue_tag=%0d ready=%b expected 4 1", issue_tag, issue_ready);
        end
    endtask

    task automatic test_cdb_operand();
        // Operand j pending on tag 2, delivered two cycles after issue.
        issue_valid = 1'b1;
        issue_qj    = 4'd2;
        issue_vk    = 32'd3;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (calculate !== 1'b0) begin
            failures++;
            $display("FAIL cdb_wait_idle: calculate=%b expected 0", calculate);
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd2;
        cdb_data  = 32'd9;
        tick();
        idle_inputs();
        checks++;
        if (calculate !== 1'b0) begin
            failures++;
            $display("FAIL cdb_capture_latency: calculate=%b expected 0", calculate);
        end
        tick();
        checks++;
        if (calculate !== 1'b1 || a !== 32'd9 || b !== 32'd3 || row !== 4'd4) begin
            failures++;
            $display("FAIL cdb_dispatch: calc=%b a=%0d b=%0d row=%0d expected 1 9 3 4", calculate, a, b, row);
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        tick();
        idle_inputs();

        // Same-cycle bypass of the CDB value into the issuing entry.
        issue_valid = 1'b1;
        issue_qj    = 4'd2;
        issue_vj    = 32'd100;
        issue_vk    = 32'd3;
        cdb_valid   = 1'b1;
        cdb_tag     = 4'd2;
        cdb_data    = 32'd9;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (calculate !== 1'b1 || a !== 32'd9 || b !== 32'd3 || row !== 4'd4) begin
            failures++;
            $display("FAIL bypass_dispatch: calc=%b a=%0d b=%0d row=%0d expected 1 9 3 4", calculate, a, b, row);
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_qj    = 4'd1;
            issue_vk    = 32'(10 + i);
            checks++;
            if (issue_tag !== 4'(4 + i)) begin
                failures++;
                $display("FAIL fill_tag%0d: issue_tag=%0d expected %0d", i, issue_tag, 4 + i);
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: issue_ready=%b expected 0", issue_ready);
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd1;
        cdb_data  = 32'd5;
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (calculate !== 1'b1 || row !== 4'(4 + k) || a !== 32'd5 || b !== 32'(10 + k)) begin
                failures++;
                $display("FAIL b2b_dispatch%0d: calc=%b row=%0d a=%0d b=%0d expected 1 %0d 5 %0d",
                         k, calculate, row, a, b, 4 + k, 10 + k);
            end
        end
    endtask

    task automatic test_full_free();
        issue_valid = 1'b1;
        issue_vj    = 32'd2;
        issue_vk    = 32'd3;
        cdb_valid   = 1'b1;
        cdb_tag     = 4'd5;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL free_cycle_ready: issue_ready=%b expected 0", issue_ready);
        end
        tick();
        cdb_valid = 1'b0;
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 4'd5) begin
            failures++;
            $display("FAIL after_free: ready=%b tag=%0d expected 1 5", issue_ready, issue_tag);
        end
        tick();
        idle_inputs();
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL refill_ready: issue_ready=%b expected 0", issue_ready);
        end
        tick();
        checks++;
        if (calculate !== 1'b1 || row !== 4'd5 || a !== 32'd2 || b !== 32'd3) begin
            failures++;
            $display("FAIL refill_dispatch: calc=%b row=%0d a=%0d b=%0d expected 1 5 2 3", calculate, row, a, b);
        end
    endtask

    task automatic test_reset_midflight();
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        tick();
        idle_inputs();
        issue_valid = 1'b1;
        issue_qj    = 4'd3;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (calculate !== 1'b0 || a !== 32'd0 || b !== 32'd0 || row !== 4'hF ||
            issue_ready !== 1'b1 || issue_tag !== 4'd4) begin
            failures++;
            $display("FAIL midflight_reset: calc=%b a=%0d b=%0d row=%h ready=%b tag=%0d expected 0 0 0 F 1 4",
                     calculate, a, b, row, issue_ready, issue_tag);
        end
        // A stale waiter on tag 3 must not wake up after reset.
        cdb_valid = 1'b1;
        cdb_tag   = 4'd3;
        cdb_data  = 32'd77;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (calculate !== 1'b0) begin
            failures++;
            $display("FAIL stale_waiter: calculate=%b expected 0", calculate);
        end
        issue_valid = 1'b1;
        issue_vj    = 32'd1;
        issue_vk    = 32'd1;
        checks++;
        if (issue_tag !== 4'd4) begin
            failures++;
            $display("FAIL post_reset_tag: issue_tag=%0d expected 4", issue_tag);
        end
        tick();
        idle_inputs();
        tick();
        checks++;
        if (calculate !== 1'b1 || row !== 4'd4 || a !== 32'd1 || b !== 32'd1) begin
            failures++;
            $display("FAIL post_reset_dispatch: calc=%b row=%0d a=%0d b=%0d expected 1 4 1 1", calculate, row, a, b);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_ready_issue();
        test_cdb_operand();
        test_back_to_back();
        test_full_free();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
